// File: rtl/washing_machine_plant_emulator.sv
// Washing machine plant model: water, heat, drum, vibration and door physics updated once per prescaled tick.
// Optional FAULT_INJECT_EN macro adds stuck-valve, blocked-drain and sensor-freeze fault inputs.
module washing_machine_plant_emulator #(
  parameter logic [15:0] TICK_DIV     = 16'd5,
  parameter logic [9:0]  LEVEL_MAX    = 10'd1000,
  parameter logic [9:0]  FILL_RATE    = 10'd8,
  parameter logic [9:0]  DRAIN_RATE   = 10'd12,
  parameter logic [6:0]  AMBIENT_TEMP = 7'd20,
  parameter logic [6:0]  TEMP_MAX     = 7'd100,
  parameter logic [9:0]  MIN_HEAT_LVL = 10'd100,
  parameter logic [7:0]  HEAT_TICKS   = 8'd4,
  parameter logic [7:0]  COOL_TICKS   = 8'd16,
  parameter logic [9:0]  SPD_STEP     = 10'd10,
  parameter logic [9:0]  VIB_SPD_TH   = 10'd400,
  parameter logic [7:0]  VIB_HOLD     = 8'd8,
  parameter logic [7:0]  LOCK_DELAY   = 8'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       water_valve,
  input  logic       drain_pump,
  input  logic       heater,
  input  logic [3:0] drum_motor,
  input  logic       door_lock,
  input  logic [7:0] load_weight,
  input  logic       imbalance,
`ifdef FAULT_INJECT_EN
  input  logic       fault_valve_stuck,
  input  logic       fault_drain_blocked,
  input  logic       fault_sensor_freeze,
`endif
  output logic       tick,
  output logic [9:0] water_level_sensor,
  output logic [6:0] temperature_adc_sensor,
  output logic [9:0] motor_speed_sensor,
  output logic       vibration_sensor,
  output logic       door_locked,
  output logic       clothes_loaded,
  output logic       dry_heat_fault
);

  logic [15:0] presc_r;
  logic [9:0]  level_r, speed_r;
  logic [6:0]  temp_r;
  logic [7:0]  heat_cnt_r, cool_cnt_r, vib_cnt_r, lock_cnt_r;

  logic               valve_s, pump_s, freeze_s, heating_s, cause_s, tick_now_s;
  logic signed [11:0] level_sum_s;
  logic [9:0]         level_next_s, target_s, speed_next_s;
  logic [6:0]         temp_next_s;
  logic [7:0]         heat_cnt_next_s, cool_cnt_next_s, vib_cnt_next_s, lock_cnt_next_s;
  logic               vib_next_s, locked_next_s;

`ifdef FAULT_INJECT_EN
  assign valve_s  = water_valve & ~fault_valve_stuck;
  assign pump_s   = drain_pump & ~fault_drain_blocked;
  assign freeze_s = fault_sensor_freeze;
`else
  assign valve_s  = water_valve;
  assign pump_s   = drain_pump;
  assign freeze_s = 1'b0;
`endif

  assign tick_now_s = (presc_r == (TICK_DIV - 16'd1));
  assign target_s   = {6'd0, drum_motor} * 10'd50;

  // Next-state physics, evaluated from the current plant state and commands.
  always_comb begin
    level_sum_s = signed'({2'b00, level_r});
    if (valve_s) level_sum_s = level_sum_s + signed'({2'b00, FILL_RATE});
    else         level_sum_s = level_sum_s;
    if (pump_s)  level_sum_s = level_sum_s - signed'({2'b00, DRAIN_RATE});
    else         level_sum_s = level_sum_s;
    if (level_sum_s < 12'sd0)                                level_next_s = 10'd0;
    else if (level_sum_s > signed'({2'b00, LEVEL_MAX}))      level_next_s = LEVEL_MAX;
    else                                                     level_next_s = level_sum_s[9:0];

    heating_s       = heater && (level_r >= MIN_HEAT_LVL);
    temp_next_s     = temp_r;
    heat_cnt_next_s = 8'd0;
    cool_cnt_next_s = 8'd0;
    if (heating_s) begin
      if (heat_cnt_r + 8'd1 >= HEAT_TICKS) begin
        if (temp_r < TEMP_MAX) temp_next_s = temp_r + 7'd1;
        else                   temp_next_s = TEMP_MAX;
      end else begin
        heat_cnt_next_s = heat_cnt_r + 8'd1;
      end
    end else begin
      if (cool_cnt_r + 8'd1 >= COOL_TICKS) begin
        if (temp_r > AMBIENT_TEMP) temp_next_s = temp_r - 7'd1;
        else                       temp_next_s = AMBIENT_TEMP;
      end else begin
        cool_cnt_next_s = cool_cnt_r + 8'd1;
      end
    end

    // Speed ramps toward the target by at most one step per tick.
    if (target_s > speed_r) begin
      if (target_s - speed_r <= SPD_STEP) speed_next_s = target_s;
      else                                speed_next_s = speed_r + SPD_STEP;
    end else begin
      if (speed_r - target_s <= SPD_STEP) speed_next_s = target_s;
      else                                speed_next_s = speed_r - SPD_STEP;
    end

    cause_s = imbalance && (speed_r >= VIB_SPD_TH);
    if (cause_s) begin
      vib_cnt_next_s = VIB_HOLD;
      vib_next_s     = 1'b1;
    end else if (vib_cnt_r != 8'd0) begin
      vib_cnt_next_s = vib_cnt_r - 8'd1;
      vib_next_s     = (vib_cnt_r != 8'd1);
    end else begin
      vib_cnt_next_s = 8'd0;
      vib_next_s     = 1'b0;
    end

    if (door_lock) begin
      if (lock_cnt_r < LOCK_DELAY) lock_cnt_next_s = lock_cnt_r + 8'd1;
      else                         lock_cnt_next_s = lock_cnt_r;
    end else begin
      lock_cnt_next_s = 8'd0;
    end
    locked_next_s = door_lock && (lock_cnt_next_s >= LOCK_DELAY);
  end

  // Prescaler, plant state and registered sensor outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_r                <= 16'd0;
      tick                   <= 1'b0;
      level_r                <= 10'd0;
      temp_r                 <= AMBIENT_TEMP;
      speed_r                <= 10'd0;
      heat_cnt_r             <= 8'd0;
      cool_cnt_r             <= 8'd0;
      vib_cnt_r              <= 8'd0;
      lock_cnt_r             <= 8'd0;
      water_level_sensor     <= 10'd0;
      temperature_adc_sensor <= AMBIENT_TEMP;
      motor_speed_sensor     <= 10'd0;
      vibration_sensor       <= 1'b0;
      door_locked            <= 1'b0;
      clothes_loaded         <= 1'b0;
      dry_heat_fault         <= 1'b0;
    end else begin
      clothes_loaded <= (load_weight != 8'd0);
      if (tick_now_s) begin
        presc_r          <= 16'd0;
        tick             <= 1'b1;
        level_r          <= level_next_s;
        temp_r           <= temp_next_s;
        speed_r          <= speed_next_s;
        heat_cnt_r       <= heat_cnt_next_s;
        cool_cnt_r       <= cool_cnt_next_s;
        vib_cnt_r        <= vib_cnt_next_s;
        lock_cnt_r       <= lock_cnt_next_s;
        vibration_sensor <= vib_next_s;
        door_locked      <= locked_next_s;
        dry_heat_fault   <= dry_heat_fault | (heater && (level_r < MIN_HEAT_LVL));
        // Frozen sensors keep their last value; internal state still evolves.
        if (!freeze_s) begin
          water_level_sensor     <= level_next_s;
          temperature_adc_sensor <= temp_next_s;
          motor_speed_sensor     <= speed_next_s;
        end else begin
          water_level_sensor     <= water_level_sensor;
          temperature_adc_sensor <= temperature_adc_sensor;
          motor_speed_sensor     <= motor_speed_sensor;
        end
      end else begin
        presc_r <= presc_r + 16'd1;
        tick    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_washing_machine_plant_emulator.sv
// Self-checking bench: directed phases plus random traffic compared against an integer plant model.
module tb_washing_machine_plant_emulator;
  logic       clk = 1'b0;
  logic       reset, water_valve, drain_pump, heater, door_lock, imbalance;
  logic [3:0] drum_motor;
  logic [7:0] load_weight;
  logic       fault_valve_stuck, fault_drain_blocked, fault_sensor_freeze;
  logic       tick, vibration_sensor, door_locked, clothes_loaded, dry_heat_fault;
  logic [9:0] water_level_sensor, motor_speed_sensor;
  logic [6:0] temperature_adc_sensor;

  int checks = 0;
  int errors = 0;

  // Behavioural plant model (integers, tick granularity).
  int m_lvl, m_temp, m_spd, m_heat, m_cool, m_since, m_run;
  int s_lvl, s_temp, s_spd;
  bit m_fault, m_vib, m_lock, frz;

  washing_machine_plant_emulator dut (
    .clk(clk), .reset(reset), .water_valve(water_valve), .drain_pump(drain_pump),
    .heater(heater), .drum_motor(drum_motor), .door_lock(door_lock),
    .load_weight(load_weight), .imbalance(imbalance),
`ifdef FAULT_INJECT_EN
    .fault_valve_stuck(fault_valve_stuck), .fault_drain_blocked(fault_drain_blocked),
    .fault_sensor_freeze(fault_sensor_freeze),
`endif
    .tick(tick), .water_level_sensor(water_level_sensor),
    .temperature_adc_sensor(temperature_adc_sensor), .motor_speed_sensor(motor_speed_sensor),
    .vibration_sensor(vibration_sensor), .door_locked(door_locked),
    .clothes_loaded(clothes_loaded), .dry_heat_fault(dry_heat_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lvl = 0; m_temp = 20; m_spd = 0; m_heat = 0; m_cool = 0; m_since = 1000; m_run = 0;
    m_fault = 0; m_vib = 0; m_lock = 0; s_lvl = 0; s_temp = 20; s_spd = 0;
  endtask

  task automatic check_reset();
    chk("rst_tick", tick, 0);
    chk("rst_level", water_level_sensor, 0);
    chk("rst_temp", temperature_adc_sensor, 20);
    chk("rst_speed", motor_speed_sensor, 0);
    chk("rst_vib", vibration_sensor, 0);
    chk("rst_door", door_locked, 0);
    chk("rst_clothes", clothes_loaded, 0);
    chk("rst_fault", dry_heat_fault, 0);
  endtask

  // Apply commands, wait for the next tick, advance the model and compare.
  task automatic step(input bit v, input bit p, input bit h, input int dm,
                      input bit dl, input bit imb, input int lw);
    int n, lvl_old, spd_old, tgt;
    bit seen;
    water_valve = v; drain_pump = p; heater = h; drum_motor = 4'(dm);
    door_lock = dl; imbalance = imb; load_weight = 8'(lw);
    seen = 1'b0; n = 0;
    while (!seen && n < 12) begin
      @(negedge clk); n++; seen = tick;
    end
    chk("tick_period", n, 5);
    lvl_old = m_lvl; spd_old = m_spd;
    m_lvl = m_lvl + (v ? 8 : 0) - (p ? 12 : 0);
    if (m_lvl < 0) m_lvl = 0;
    if (m_lvl > 1000) m_lvl = 1000;
    if (h && lvl_old >= 100) begin
      m_cool = 0; m_heat++;
      if (m_heat == 4) begin m_heat = 0; if (m_temp < 100) m_temp++; end
    end else begin
      m_heat = 0; m_cool++;
      if (m_cool == 16) begin m_cool = 0; if (m_temp > 20) m_temp--; end
    end
    if (h && lvl_old < 100) m_fault = 1;
    tgt = dm * 50;
    if (tgt - m_spd <= 10 && m_spd - tgt <= 10) m_spd = tgt;
    else m_spd = m_spd + ((tgt > m_spd) ? 10 : -10);
    if (imb && spd_old >= 400) m_since = 0;
    else if (m_since < 1000) m_since++;
    m_vib = (m_since < 8);
    m_run = dl ? m_run + 1 : 0;
    m_lock = (m_run >= 3);
    if (!frz) begin s_lvl = m_lvl; s_temp = m_temp; s_spd = m_spd; end
    chk("level", water_level_sensor, s_lvl);
    chk("temp", temperature_adc_sensor, s_temp);
    chk("speed", motor_speed_sensor, s_spd);
    chk("vibration", vibration_sensor, m_vib);
    chk("door_locked", door_locked, m_lock);
    chk("dry_heat_fault", dry_heat_fault, m_fault);
    chk("clothes_loaded", clothes_loaded, lw != 0);
  endtask

  initial begin
    reset = 1'b0; water_valve = 0; drain_pump = 0; heater = 0; drum_motor = 4'd0;
    door_lock = 0; imbalance = 0; load_weight = 8'd0; frz = 0;
    fault_valve_stuck = 0; fault_drain_blocked = 0; fault_sensor_freeze = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset();
    reset = 1'b1;

    // Fill to saturation.
    for (int i = 0; i < 130; i++) step(1, 0, 0, 0, 0, 0, 5);
    chk("fill_saturated", water_level_sensor, 1000);
    // Fill and drain together, then drain to zero.
    for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0, 0, 5);
    chk("net_minus4", water_level_sensor, 920);
    for (int i = 0; i < 80; i++) step(0, 1, 0, 0, 0, 0, 0);
    chk("drain_clamped", water_level_sensor, 0);
    // Heat, cool, then dry heat fault.
    for (int i = 0; i < 15; i++) step(1, 0, 0, 0, 0, 0, 9);
    for (int i = 0; i < 80; i++) step(0, 0, 1, 0, 0, 0, 9);
    chk("heated", temperature_adc_sensor, 40);
    for (int i = 0; i < 320; i++) step(0, 0, 0, 0, 0, 0, 9);
    chk("cooled", temperature_adc_sensor, 20);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 0, 9);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0, 0, 9);
    chk("dry_fault_set", dry_heat_fault, 1);
    // Spin up with imbalance, then stop.
    for (int i = 0; i < 42; i++) step(0, 0, 0, 8, 0, 1, 9);
    chk("spin_400", motor_speed_sensor, 400);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 1, 9);
    chk("vib_released", vibration_sensor, 0);
    // Door lock: full delay, aborted delay, relock.
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0, 0);
    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 5),
           int'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 3)));
    // Reset in the middle of a fill wins over everything.
    for (int i = 0; i < 5; i++) step(1, 0, 1, 9, 1, 1, 7);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset();
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) step(1, 0, 0, 3, 0, 0, 7);
`ifdef FAULT_INJECT_EN
    fault_sensor_freeze = 1; frz = 1;
    for (int i = 0; i < 6; i++) step(1, 0, 0, 3, 0, 0, 7);
    fault_sensor_freeze = 0; frz = 0;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 3, 0, 0, 7);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
